fifo_apb: RTL and testbench

APB3 slave that places a word-wide FIFO mailbox behind one select line of the AXI-to-APB bridge. Each slave port of the bridge currently ends in a memory. This block replaces one of them with a queue: the host pushes words by writing a data register and pops them by reading the same register. Status, control and a level-triggered interrupt output are provided for the host's polling or IRQ flow.

---
 rtl/fifo_apb.sv | 162 ++++++++++++++++
 tb/tb_fifo_apb.sv | 422 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_apb.sv
// rtl/fifo_apb.sv - APB3 slave exposing a word-wide FIFO mailbox with status, control and IRQ
//
// Purpose: the host pushes words by writing DATA (0x0) and pops them by reading DATA.
//          STATUS (0x4) reports empty/full/irq_pending/count. CONTROL (0x8) holds the
//          write-1 flush bit and irq_en. THRESHOLD (0xC) holds the IRQ level.
// Ports:
//   PCLK, PRESETn        clock, synchronous active-low reset
//   PSEL, PENABLE        APB select and access phase
//   PADDR, PWRITE        address (only [3:2] decoded), direction
//   PWDATA / PRDATA      write data in, registered read data out
//   PREADY, PSLVERR      zero-wait-state completion, error on DATA full-write/empty-read
//   PSTRB, PPROT         APB4-only, ignored
//   IRQ                  registered level interrupt, active-high
module fifo_apb #(
  parameter int WIDTH_PAD = 32,
  parameter int WIDTH_PDA = 32,
  parameter int DEPTH     = 16
) (
  input  logic                 PCLK,
  input  logic                 PRESETn,
  input  logic                 PSEL,
  input  logic [WIDTH_PAD-1:0] PADDR,
  input  logic                 PENABLE,
  input  logic                 PWRITE,
  input  logic [WIDTH_PDA-1:0] PWDATA,
  output logic [WIDTH_PDA-1:0] PRDATA,
  output logic                 PREADY,
  output logic                 PSLVERR,
`ifdef AMBA_APB4
  input  logic [WIDTH_PDA/8-1:0] PSTRB,
  input  logic [2:0]           PPROT,
`endif
  output logic                 IRQ
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  localparam logic [1:0] A_DATA   = 2'd0;
  localparam logic [1:0] A_STATUS = 2'd1;
  localparam logic [1:0] A_CTRL   = 2'd2;
  localparam logic [1:0] A_THRESH = 2'd3;

  logic [WIDTH_PDA-1:0] mem_q [DEPTH];

  logic [PW-1:0]        wptr_q, wptr_d;
  logic [PW-1:0]        rptr_q, rptr_d;
  logic                 irq_en_q, irq_en_d;
  logic [7:0]           thresh_q, thresh_d;
  logic [WIDTH_PDA-1:0] prdata_q, prdata_d;
  logic                 irq_q, irq_d;

  logic [1:0]           addr_sel;
  logic                 setup_rd;
  logic                 access;
  logic [PW-1:0]        count;
  logic [8:0]           count_ext;
  logic                 empty;
  logic                 full;
  logic                 irq_pending;
  logic                 push_ok;
  logic [31:0]          status_word;
  logic [WIDTH_PDA-1:0] rd_mux;
  logic                 unused_ok;

  assign addr_sel  = PADDR[3:2];
  assign setup_rd  = PSEL & ~PENABLE & ~PWRITE;
  // Gating with PRESETn makes a reset during the access phase abort the transfer.
  assign access    = PSEL & PENABLE & PRESETn;

  // Pointer difference modulo 2^PW; the extra MSB distinguishes full from empty.
  assign count     = wptr_q - rptr_q;
  assign count_ext = 9'(count);
  assign empty     = (count == '0);
  assign full      = (count == PW'(DEPTH));
  assign irq_pending = (count_ext >= {1'b0, thresh_q}) && (thresh_q != 8'd0);

  assign push_ok   = access & PWRITE & (addr_sel == A_DATA) & ~full;

  assign status_word = {8'h00, count_ext[7:0], 13'h0000, irq_pending, full, empty};

  always_comb begin
    rd_mux = '0;
    case (addr_sel)
      A_DATA:   rd_mux = empty ? '0 : mem_q[rptr_q[AW-1:0]];
      A_STATUS: rd_mux = WIDTH_PDA'(status_word);
      A_CTRL:   rd_mux = WIDTH_PDA'({irq_en_q, 1'b0});
      A_THRESH: rd_mux = WIDTH_PDA'(thresh_q);
      default:  rd_mux = '0;
    endcase
  end

  always_comb begin
    wptr_d   = wptr_q;
    rptr_d   = rptr_q;
    irq_en_d = irq_en_q;
    thresh_d = thresh_q;
    prdata_d = prdata_q;
    // Read data is captured at the setup edge so it is stable across the access phase.
    if (setup_rd) begin
      prdata_d = rd_mux;
    end
    if (access) begin
      if (PWRITE) begin
        case (addr_sel)
          A_DATA: begin
            if (!full) wptr_d = wptr_q + PW'(1);
          end
          A_CTRL: begin
            if (PWDATA[0]) begin
              wptr_d = '0;
              rptr_d = '0;
            end
            irq_en_d = PWDATA[1];
          end
          A_THRESH: thresh_d = PWDATA[7:0];
          default: ;
        endcase
      end else if (addr_sel == A_DATA && !empty) begin
        rptr_d = rptr_q + PW'(1);
      end
    end
    irq_d = irq_pending & irq_en_q;
  end

  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      irq_en_q <= 1'b0;
      thresh_q <= 8'd0;
      prdata_q <= '0;
      irq_q    <= 1'b0;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      irq_en_q <= irq_en_d;
      thresh_q <= thresh_d;
      prdata_q <= prdata_d;
      irq_q    <= irq_d;
    end
  end

  // Storage has no reset; contents behind the pointers are never observed.
  always_ff @(posedge PCLK) begin
    if (push_ok) begin
      mem_q[wptr_q[AW-1:0]] <= PWDATA;
    end
  end

  assign PREADY  = access;
  assign PSLVERR = access & (addr_sel == A_DATA) & (PWRITE ? full : empty);
  assign PRDATA  = prdata_q;
  assign IRQ     = irq_q;

`ifdef AMBA_APB4
  assign unused_ok = ^{PADDR[WIDTH_PAD-1:4], PADDR[1:0], count_ext[8], PSTRB, PPROT};
`else
  assign unused_ok = ^{PADDR[WIDTH_PAD-1:4], PADDR[1:0], count_ext[8]};
`endif

endmodule

// File: tb/tb_fifo_apb.sv
// tb/tb_fifo_apb.sv - self-checking bench for fifo_apb against a queue-based mailbox model
module tb_fifo_apb;

  localparam int DEPTH = 16;

  logic        PCLK = 1'b0;
  logic        PRESETn = 1'b0;
  logic        PSEL = 1'b0;
  logic [31:0] PADDR = '0;
  logic        PENABLE = 1'b0;
  logic        PWRITE = 1'b0;
  logic [31:0] PWDATA = '0;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;
  logic        IRQ;
`ifdef AMBA_APB4
  logic [3:0]  PSTRB = 4'hf;
  logic [2:0]  PPROT = 3'b000;
`endif

  fifo_apb #(.WIDTH_PAD(32), .WIDTH_PDA(32), .DEPTH(DEPTH)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(PSEL), .PADDR(PADDR), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
`ifdef AMBA_APB4
    .PSTRB(PSTRB), .PPROT(PPROT),
`endif
    .IRQ(IRQ)
  );

  always #5 PCLK = ~PCLK;

  int n_checks = 0;
  int n_fail = 0;

  // Reference model: mailbox contents, threshold level and interrupt enable.
  logic [31:0] model_q[$];
  int          m_thresh = 0;
  bit          m_en = 0;

  function automatic bit m_pending();
    return (m_thresh != 0) && (model_q.size() >= m_thresh);
  endfunction

  function automatic logic [31:0] exp_status();
    logic [31:0] s;
    s = '0;
    s[0] = (model_q.size() == 0);
    s[1] = (model_q.size() == DEPTH);
    s[2] = m_pending();
    s[23:16] = 8'(model_q.size());
    return s;
  endfunction

  // Bus tasks start and end 1 time unit after a rising edge with the bus idle,
  // so consecutive calls produce back-to-back transfers.
  task automatic apb_write(input logic [3:0] addr, input logic [31:0] d, output logic err);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = {28'h0, addr}; PWDATA = d;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    #2;
    err = PSLVERR;
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic apb_read(input logic [3:0] addr, output logic [31:0] d, output logic err);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = {28'h0, addr};
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    #2;
    d = PRDATA;
    err = PSLVERR;
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic do_reset();
    PRESETn = 1'b0;
    PSEL = 1'b0; PENABLE = 1'b0;
    repeat (3) @(posedge PCLK);
    #1;
    PRESETn = 1'b1;
    model_q.delete();
    m_thresh = 0;
    m_en = 0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    logic e;
    do_reset();
    n_checks++;
    if (IRQ !== 1'b0 || PREADY !== 1'b0 || PRDATA !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: IRQ=%b PREADY=%b PRDATA=%h, want 0 0 0", IRQ, PREADY, PRDATA);
    end
    apb_read(4'h4, d, e);
    n_checks++;
    if (d !== 32'h00000001 || e !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_status: got %h err=%b, want 00000001 err=0", d, e);
    end
    apb_read(4'hC, d, e);
    n_checks++;
    if (d !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_threshold: got %h, want 0", d);
    end
  endtask

  task automatic test_ordering();
    logic [31:0] d;
    logic e;
    logic [31:0] vals [3] = '{32'h11111111, 32'h22222222, 32'h33333333};
    foreach (vals[i]) begin
      apb_write(4'h0, vals[i], e);
      model_q.push_back(vals[i]);
    end
    apb_read(4'h4, d, e);
    n_checks++;
    if (d !== exp_status() || d[23:16] !== 8'd3) begin
      n_fail++;
      $display("FAIL order_status: got %h, want %h", d, exp_status());
    end
    foreach (vals[i]) begin
      apb_read(4'h0, d, e);
      n_checks++;
      if (d !== model_q[0] || e !== 1'b0) begin
        n_fail++;
        $display("FAIL order_pop%0d: got %h err=%b, want %h err=0", i, d, e, model_q[0]);
      end
      void'(model_q.pop_front());
    end
    apb_read(4'h4, d, e);
    n_checks++;
    if (d !== 32'h00000001) begin
      n_fail++;
      $display("FAIL order_empty: got %h, want 00000001", d);
    end
  endtask

  task automatic test_full_wrap();
    logic [31:0] d;
    logic e;
    for (int i = 0; i < DEPTH; i++) begin
      apb_write(4'h0, i, e);
      model_q.push_back(i);
    end
    apb_read(4'h4, d, e);
    n_checks++;
    if (d !== 32'h00100002) begin
      n_fail++;
      $display("FAIL full_status: got %h, want 00100002", d);
    end
    apb_write(4'h0, 32'hdeadbeef, e);
    n_checks++;
    if (e !== 1'b1) begin
      n_fail++;
      $display("FAIL full_push_err: got err=%b, want 1", e);
    end
    apb_read(4'h4, d, e);
    n_checks++;
    if (d !== 32'h00100002) begin
      n_fail++;
      $display("FAIL full_unchanged: got %h, want 00100002", d);
    end
    for (int i = 0; i < 8; i++) begin
      apb_read(4'h0, d, e);
      n_checks++;
      if (d !== model_q[0] || e !== 1'b0) begin
        n_fail++;
        $display("FAIL wrap_pop_a%0d: got %h err=%b, want %h", i, d, e, model_q[0]);
      end
      void'(model_q.pop_front());
    end
    for (int i = DEPTH; i < DEPTH + 8; i++) begin
      apb_write(4'h0, i, e);
      model_q.push_back(i);
    end
    for (int i = 0; i < DEPTH; i++) begin
      apb_read(4'h0, d, e);
      n_checks++;
      if (d !== 32'(i + 8) || e !== 1'b0) begin
        n_fail++;
        $display("FAIL wrap_pop_b%0d: got %h err=%b, want %h", i, d, e, 32'(i + 8));
      end
      void'(model_q.pop_front());
    end
  endtask

  task automatic test_empty_read();
    logic [31:0] d;
    logic e;
    apb_read(4'h0, d, e);
    n_checks++;
    if (d !== 32'h0 || e !== 1'b1) begin
      n_fail++;
      $display("FAIL empty_read: got %h err=%b, want 00000000 err=1", d, e);
    end
    apb_read(4'h4, d, e);
    n_checks++;
    if (d !== 32'h00000001) begin
      n_fail++;
      $display("FAIL empty_count: got %h, want 00000001", d);
    end
  endtask

  task automatic test_irq();
    logic [31:0] d;
    logic e;
    apb_write(4'hC, 32'd4, e);
    m_thresh = 4;
    apb_write(4'h8, 32'h2, e);
    m_en = 1;
    for (int i = 0; i < 4; i++) begin
      apb_write(4'h0, 32'ha0 + i, e);
      model_q.push_back(32'ha0 + i);
    end
    n_checks++;
    if (IRQ !== 1'b0) begin
      n_fail++;
      $display("FAIL irq_at_commit: got %b, want 0", IRQ);
    end
    @(posedge PCLK); #1;
    n_checks++;
    if (IRQ !== 1'b1) begin
      n_fail++;
      $display("FAIL irq_rise: got %b, want 1", IRQ);
    end
    apb_read(4'h4, d, e);
    n_checks++;
    if (d !== 32'h00040004) begin
      n_fail++;
      $display("FAIL irq_status: got %h, want 00040004", d);
    end
    apb_read(4'h0, d, e);
    void'(model_q.pop_front());
    @(posedge PCLK); #1;
    n_checks++;
    if (IRQ !== 1'b0) begin
      n_fail++;
      $display("FAIL irq_fall: got %b, want 0", IRQ);
    end
    apb_write(4'h0, 32'hb0, e);
    apb_write(4'h0, 32'hb1, e);
    model_q.push_back(32'hb0);
    model_q.push_back(32'hb1);
    @(posedge PCLK); #1;
    n_checks++;
    if (IRQ !== 1'b1 || model_q.size() != 5) begin
      n_fail++;
      $display("FAIL irq_five: got %b, want 1", IRQ);
    end
    apb_write(4'h8, 32'h3, e);
    model_q.delete();
    @(posedge PCLK); #1;
    apb_read(4'h4, d, e);
    n_checks++;
    if (d !== 32'h00000001 || IRQ !== 1'b0) begin
      n_fail++;
      $display("FAIL irq_clear: status %h IRQ=%b, want 00000001 IRQ=0", d, IRQ);
    end
    apb_read(4'h8, d, e);
    n_checks++;
    if (d !== 32'h2) begin
      n_fail++;
      $display("FAIL ctrl_readback: got %h, want 00000002", d);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d, w;
    logic e;
    for (int i = 0; i < 6; i++) begin
      w = $urandom;
      apb_write(4'h0, w, e);
      model_q.push_back(w);
      apb_read(4'h4, d, e);
      n_checks++;
      if (d[23:16] !== 8'd1) begin
        n_fail++;
        $display("FAIL b2b_count1_%0d: got %0d, want 1", i, d[23:16]);
      end
      apb_read(4'h0, d, e);
      n_checks++;
      if (d !== w || e !== 1'b0) begin
        n_fail++;
        $display("FAIL b2b_pop_%0d: got %h err=%b, want %h err=0", i, d, e, w);
      end
      void'(model_q.pop_front());
      apb_read(4'h4, d, e);
      n_checks++;
      if (d[23:16] !== 8'd0) begin
        n_fail++;
        $display("FAIL b2b_count0_%0d: got %0d, want 0", i, d[23:16]);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] d, w;
    logic e;
    int op, lvl;
    for (int i = 0; i < 200; i++) begin
      op = $urandom_range(0, 9);
      if (op < 4) begin
        w = $urandom;
        apb_write(4'h0, w, e);
        n_checks++;
        if (e !== (model_q.size() == DEPTH)) begin
          n_fail++;
          $display("FAIL rnd_push_%0d: err=%b, want %b", i, e, model_q.size() == DEPTH);
        end
        if (model_q.size() < DEPTH) model_q.push_back(w);
      end else if (op < 7) begin
        apb_read(4'h0, d, e);
        n_checks++;
        if (model_q.size() == 0) begin
          if (d !== 32'h0 || e !== 1'b1) begin
            n_fail++;
            $display("FAIL rnd_pop_%0d: got %h err=%b, want 0 err=1", i, d, e);
          end
        end else begin
          if (d !== model_q[0] || e !== 1'b0) begin
            n_fail++;
            $display("FAIL rnd_pop_%0d: got %h err=%b, want %h err=0", i, d, e, model_q[0]);
          end
          void'(model_q.pop_front());
        end
      end else if (op < 8) begin
        apb_read(4'h4, d, e);
        n_checks++;
        if (d !== exp_status()) begin
          n_fail++;
          $display("FAIL rnd_status_%0d: got %h, want %h", i, d, exp_status());
        end
      end else if (op < 9) begin
        lvl = $urandom_range(0, 18);
        apb_write(4'hC, 32'(lvl) | 32'hffff_ff00, e);
        m_thresh = lvl;
        apb_read(4'hC, d, e);
        n_checks++;
        if (d !== 32'(lvl)) begin
          n_fail++;
          $display("FAIL rnd_thresh_%0d: got %h, want %h", i, d, 32'(lvl));
        end
      end else begin
        w = {$urandom} & 32'h2;
        apb_write(4'h8, w, e);
        m_en = w[1];
      end
      @(posedge PCLK); #1;
      n_checks++;
      if (IRQ !== (m_pending() && m_en)) begin
        n_fail++;
        $display("FAIL rnd_irq_%0d: got %b, want %b", i, IRQ, m_pending() && m_en);
      end
    end
  endtask

  task automatic test_reset_mid_transfer();
    logic [31:0] d;
    logic e;
    apb_write(4'hC, 32'd1, e);
    apb_write(4'h8, 32'h2, e);
    apb_write(4'h0, 32'h5555aaaa, e);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 32'h0; PWDATA = 32'h12345678;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    PRESETn = 1'b0;
    #1;
    n_checks++;
    if (PREADY !== 1'b0 || PSLVERR !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid_comb: PREADY=%b PSLVERR=%b, want 0 0", PREADY, PSLVERR);
    end
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
    n_checks++;
    if (PRDATA !== 32'h0 || IRQ !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid_regs: PRDATA=%h IRQ=%b, want 0 0", PRDATA, IRQ);
    end
    PRESETn = 1'b1;
    model_q.delete();
    m_thresh = 0;
    m_en = 0;
    apb_read(4'h4, d, e);
    n_checks++;
    if (d !== 32'h00000001) begin
      n_fail++;
      $display("FAIL rst_mid_status: got %h, want 00000001", d);
    end
    apb_read(4'h8, d, e);
    n_checks++;
    if (d !== 32'h0) begin
      n_fail++;
      $display("FAIL rst_mid_ctrl: got %h, want 0", d);
    end
    apb_read(4'hC, d, e);
    n_checks++;
    if (d !== 32'h0) begin
      n_fail++;
      $display("FAIL rst_mid_thresh: got %h, want 0", d);
    end
  endtask

  initial begin
    test_reset();
    test_ordering();
    test_full_wrap();
    test_empty_read();
    test_irq();
    test_back_to_back();
    test_random();
    test_reset_mid_transfer();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
